// File: rtl/subneg_bus_pkg.sv
// subneg_bus_pkg: definitions shared by the subneg core, the memory bus sequencer and any
// memory-side model that talks over the multiplexed 8-bit address/data pins.
//   - BUS_W                   : address/data width on the pins
//   - BUS_OE_IN / BUS_OE_OUT  : pin output-enable patterns (release / drive)
//   - bus_state_e             : sequencer state encoding
package subneg_bus_pkg;

    localparam int unsigned BUS_W = 8;
    localparam int unsigned CNT_W = 4;

    localparam logic [BUS_W-1:0] BUS_OE_IN  = 8'h00;
    localparam logic [BUS_W-1:0] BUS_OE_OUT = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAhold,
        StRd,
        StWsetup,
        StWpulse,
        StWhold
    } bus_state_e;

endpackage

// File: rtl/subneg_mem_bus.sv
// subneg_mem_bus: bus-master sequencer between the subneg core and external memory on the
// shared multiplexed address/data pins. Takes one read or write request at a time over a
// valid/ready handshake, runs the LE address-latch phase followed by the MOE read or MWE
// write strobe phase, and returns a one-cycle rsp_valid pulse (with rsp_rdata on reads).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we/addr/wdata     request fields, latched at the accept edge
//   rsp_valid/rsp_rdata   completion pulse; rsp_rdata holds the last read value
//   bus_out/bus_oe/bus_in pin data out, pin output enables, pin data in
//   le/moe/mwe            address-latch enable, memory output enable, memory write enable
//
// Every output is a flop whose next value is decoded from the next state, so the pins
// change cleanly on clock edges.
module subneg_mem_bus
    import subneg_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned WE_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [BUS_W-1:0] req_addr,
    input  logic [BUS_W-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [BUS_W-1:0] rsp_rdata,
    output logic [BUS_W-1:0] bus_out,
    output logic [BUS_W-1:0] bus_oe,
    input  logic [BUS_W-1:0] bus_in,
    output logic             le,
    output logic             moe,
    output logic             mwe
);

    localparam logic [CNT_W-1:0] RdLoad = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WeLoad = CNT_W'(WE_CYCLES - 1);

    bus_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [BUS_W-1:0] addr_q, addr_d;
    logic [BUS_W-1:0] wdata_q, wdata_d;

    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [BUS_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [BUS_W-1:0] bus_out_q, bus_out_d;
    logic [BUS_W-1:0] bus_oe_q, bus_oe_d;
    logic             le_q, le_d;
    logic             moe_q, moe_d;
    logic             mwe_q, mwe_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            StIdle: begin
                // req_ready_q is low in the first cycle after reset, so no accept there.
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = StAddr;
                end
            end
            StAddr:  state_d = StAhold;
            StAhold: begin
                if (we_q) begin
                    state_d = StWsetup;
                end else begin
                    state_d = StRd;
                    cnt_d   = RdLoad;
                end
            end
            StRd: begin
                if (cnt_q == '0) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus_in;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWsetup: begin
                state_d = StWpulse;
                cnt_d   = WeLoad;
            end
            StWpulse: begin
                if (cnt_q == '0) begin
                    state_d = StWhold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWhold: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Output decode from the next state; flops then present it during that state.
        req_ready_d = (state_d == StIdle);
        le_d        = (state_d == StAddr);
        moe_d       = (state_d == StRd);
        mwe_d       = (state_d == StWpulse);
        bus_out_d   = '0;
        bus_oe_d    = BUS_OE_IN;
        case (state_d)
            StAddr, StAhold: begin
                bus_out_d = addr_d;
                bus_oe_d  = BUS_OE_OUT;
            end
            StWsetup, StWpulse, StWhold: begin
                bus_out_d = wdata_d;
                bus_oe_d  = BUS_OE_OUT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            bus_out_q   <= '0;
            bus_oe_q    <= BUS_OE_IN;
            le_q        <= 1'b0;
            moe_q       <= 1'b0;
            mwe_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            bus_out_q   <= bus_out_d;
            bus_oe_q    <= bus_oe_d;
            le_q        <= le_d;
            moe_q       <= moe_d;
            mwe_q       <= mwe_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign bus_out   = bus_out_q;
    assign bus_oe    = bus_oe_q;
    assign le        = le_q;
    assign moe       = moe_q;
    assign mwe       = mwe_q;

endmodule

// File: tb/tb_subneg_mem_bus.sv
// Bench for subneg_mem_bus: two instances (default timing, and WAIT_CYCLES=3/WE_CYCLES=2),
// each attached to a small pin-level memory (external address latch + RAM).
module tb_subneg_mem_bus;

    logic       clk = 1'b0;
    logic       reset[2];
    logic       req_valid[2];
    logic       req_ready[2];
    logic       req_we[2];
    logic [7:0] req_addr[2];
    logic [7:0] req_wdata[2];
    logic       rsp_valid[2];
    logic [7:0] rsp_rdata[2];
    logic [7:0] bus_out[2];
    logic [7:0] bus_oe[2];
    logic [7:0] bus_in[2];
    logic       le[2];
    logic       moe[2];
    logic       mwe[2];

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;

    logic [7:0] ref_mem[2][256];
    logic [7:0] last_rdata[2];

    typedef struct {
        int         dut;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         hold;
        logic [7:0] exp_rdata;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    subneg_mem_bus #(.WAIT_CYCLES(1), .WE_CYCLES(1)) dut0 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .bus_out(bus_out[0]), .bus_oe(bus_oe[0]), .bus_in(bus_in[0]),
        .le(le[0]), .moe(moe[0]), .mwe(mwe[0])
    );

    subneg_mem_bus #(.WAIT_CYCLES(3), .WE_CYCLES(2)) dut1 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .bus_out(bus_out[1]), .bus_oe(bus_oe[1]), .bus_in(bus_in[1]),
        .le(le[1]), .moe(moe[1]), .mwe(mwe[1])
    );

    function automatic logic [7:0] pat(input int a);
        return 8'(a * 7 + 8'h14);
    endfunction

    // Pin-level memory: latch the address while LE is high, write on MWE, drive on MOE.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        logic [7:0] mem[256];
        logic [7:0] lat;
        always @(posedge clk) begin
            if (reset[g]) begin
                for (int i = 0; i < 256; i++) mem[i] <= pat(i);
                lat <= 8'h00;
            end else begin
                if (le[g]) lat <= bus_out[g];
                if (mwe[g]) mem[lat] <= bus_out[g];
            end
        end
        assign bus_in[g] = moe[g] ? mem[lat] : 8'hEE;
    end

    task automatic check(input string nm, input int d, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s dut%0d t=%0t: got %h want %h", nm, d, $time, got, want);
        end
    endtask

    function automatic logic [20:0] act_vec(input int d);
        return {req_ready[d], rsp_valid[d], le[d], moe[d], mwe[d], bus_oe[d], bus_out[d]};
    endfunction

    // Expected pins k cycles after the accept edge, from the documented phase sequence.
    function automatic logic [20:0] exp_vec(input int d, input bit we, input logic [7:0] addr,
                                            input logic [7:0] wdata, input int k);
        int e, len;
        logic rr, rv, l, mo, mw;
        logic [7:0] oe, out;
        e   = (d == 0) ? 1 : 2;
        len = we ? 5 + e : 3 + ((d == 0) ? 1 : 3);
        rr = 0; rv = 0; l = 0; mo = 0; mw = 0; oe = 8'h00; out = 8'h00;
        if (k == len) begin
            rr = 1; rv = 1;
        end else if (k == 1) begin
            l = 1; oe = 8'hFF; out = addr;
        end else if (k == 2) begin
            oe = 8'hFF; out = addr;
        end else if (!we) begin
            mo = 1;
        end else begin
            oe = 8'hFF; out = wdata; mw = (k >= 4 && k <= 3 + e);
        end
        return {rr, rv, l, mo, mw, oe, out};
    endfunction

    task automatic do_txn(input int d, input bit we, input logic [7:0] addr,
                          input logic [7:0] wdata, input bit hold, input logic [7:0] exp_rd);
        int len, n;
        len = we ? 5 + ((d == 0) ? 1 : 2) : 3 + ((d == 0) ? 1 : 3);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready[d]) begin
            check("accept_timeout", d, 0, 1);
            req_valid[d] = 1'b0;
            return;
        end
        for (int k = 1; k <= len; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                // Request fields must be ignored once accepted.
                req_valid[d] = hold;
                req_we[d]    = 1'($urandom);
                req_addr[d]  = 8'($urandom);
                req_wdata[d] = 8'($urandom);
            end
            check(we ? "write_pins" : "read_pins", d, 32'(act_vec(d)),
                  32'(exp_vec(d, we, addr, wdata, k)));
        end
        check("rsp_rdata", d, 32'(rsp_rdata[d]), 32'(exp_rd));
        if (we) ref_mem[d][addr] = wdata;
        else last_rdata[d] = exp_rd;
    endtask

    // Bus invariants on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                logic ok;
                ok = (!moe[d] || bus_oe[d] == 8'h00) && (!mwe[d] || bus_oe[d] == 8'hFF) &&
                     ((32'(le[d]) + 32'(moe[d]) + 32'(mwe[d])) <= 1) &&
                     (bus_oe[d] == 8'h00 || bus_oe[d] == 8'hFF);
                n_checks++;
                if (!ok) begin
                    n_fails++;
                    $display("FAIL invariant dut%0d t=%0t: le=%b moe=%b mwe=%b oe=%h", d, $time,
                             le[d], moe[d], mwe[d], bus_oe[d]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_addr[d] = 8'h00; req_wdata[d] = 8'h00; last_rdata[d] = 8'h00;
            for (int i = 0; i < 256; i++) ref_mem[d][i] = pat(i);
        end

        tbl[0] = '{0, 1'b0, 8'h15, 8'h00, 1'b0, 8'hA7};
        tbl[1] = '{0, 1'b1, 8'h21, 8'h3C, 1'b1, 8'hA7};
        tbl[2] = '{0, 1'b0, 8'h21, 8'h00, 1'b0, 8'h3C};
        tbl[3] = '{1, 1'b0, 8'h40, 8'h00, 1'b0, 8'hD4};
        tbl[4] = '{1, 1'b1, 8'h41, 8'h5B, 1'b0, 8'hD4};

        // Reset held for two edges.
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            check("in_reset_pins", d, 32'(act_vec(d)), 32'h0);
            check("in_reset_rdata", d, 32'(rsp_rdata[d]), 32'h0);
        end
        reset[0] = 1'b0; reset[1] = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            check("after_reset_pins", d, 32'(act_vec(d)), 32'h100000);
            check("after_reset_rdata", d, 32'(rsp_rdata[d]), 32'h0);
        end

        // Directed vectors.
        for (int i = 0; i < 5; i++) begin
            do_txn(tbl[i].dut, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
                   tbl[i].exp_rdata);
            if (!tbl[i].hold) req_valid[tbl[i].dut] = 1'b0;
        end

        // Random traffic against the reference memory.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                bit         we, hold;
                logic [7:0] a, wd, ex;
                int         gaps;
                we   = 1'($urandom);
                hold = 1'($urandom);
                a    = 8'($urandom);
                wd   = 8'($urandom);
                ex   = we ? last_rdata[d] : ref_mem[d][a];
                do_txn(d, we, a, wd, hold, ex);
                if (!hold) begin
                    req_valid[d] = 1'b0;
                    gaps = $urandom_range(0, 2);
                    for (int g = 0; g < gaps; g++) begin
                        @(posedge clk); #1;
                        check("idle_pins", d, 32'(act_vec(d)), 32'h100000);
                    end
                end
            end
            req_valid[d] = 1'b0;
            @(posedge clk); #1;
        end

        // Reset during WPULSE on the slow instance.
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 8'h41; req_wdata[1] = 8'h99;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wpulse_before_abort", 1, 32'(act_vec(1)), 32'(exp_vec(1, 1'b1, 8'h41, 8'h99, 4)));
        reset[1] = 1'b1;
        @(posedge clk); #1;
        check("abort_pins", 1, 32'(act_vec(1)), 32'h0);
        check("abort_rdata", 1, 32'(rsp_rdata[1]), 32'h0);
        reset[1] = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[1][i] = pat(i);
        last_rdata[1] = 8'h00;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (rsp_valid[1]) seen = 1'b1;
        end
        check("no_rsp_after_abort", 1, 32'(seen), 32'h0);
        do_txn(1, 1'b0, 8'h41, 8'h00, 1'b0, pat(8'h41));
        req_valid[1] = 1'b0;
        @(posedge clk); #1;

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
